// File: rtl/ltc_reader.sv
// ltc_reader: biphase-mark SMPTE LTC decoder producing BCD timecode, user bits, flags and lock status
module ltc_reader #(
  parameter int MIN_INTERVAL = 1500,
  parameter int THRESHOLD = 4000,
  parameter int MAX_INTERVAL = 8000,
  parameter int CNT_W = 14,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ltc_in,
  output logic [5:0]  hrs,
  output logic [6:0]  min,
  output logic [6:0]  sec,
  output logic [5:0]  frm,
  output logic [31:0] user_bits,
  output logic        drop_frame,
  output logic        color_frame,
  output logic        frame_valid,
  output logic        locked,
  output logic        error
);
  localparam logic [CNT_W-1:0] MIN_C = CNT_W'(MIN_INTERVAL);
  localparam logic [CNT_W-1:0] THR_C = CNT_W'(THRESHOLD);
  localparam logic [CNT_W-1:0] SAT_C = CNT_W'(MAX_INTERVAL + 1);
  localparam int LW = $clog2(LOCK_FRAMES + 1);
  localparam logic [LW-1:0] LOCK_C = LW'(LOCK_FRAMES);
  localparam logic [15:0] SYNC = 16'b0011111111111101;
  logic s1, s2, s3, pending, timed_out, emit_d;
  logic [CNT_W-1:0] cnt;
  logic [79:0] sr;
  logic [6:0] bits_ok, bit_cnt;
  logic [LW-1:0] lock_cnt, lock_nxt;
  logic edge_det, timed, classify, glitch, is_short, is_long, biphase, emit;
  logic to_fault, overrun, fault, sync_hit, full, bcd_ok, good, bad_bcd;
  logic [3:0] frm_u, sec_u, min_u, hrs_u;
  logic [1:0] frm_d, hrs_d;
  logic [2:0] sec_d, min_d;
  logic [31:0] ub;
  logic unused_bits;

  function automatic logic [3:0] rev4(input logic [3:0] v);
    return {v[0], v[1], v[2], v[3]};
  endfunction

  function automatic logic [2:0] rev3(input logic [2:0] v);
    return {v[0], v[1], v[2]};
  endfunction

  function automatic logic [1:0] rev2(input logic [1:0] v);
    return {v[0], v[1]};
  endfunction

  assign frm_u = rev4(sr[79:76]);
  assign frm_d = rev2(sr[71:70]);
  assign sec_u = rev4(sr[63:60]);
  assign sec_d = rev3(sr[55:53]);
  assign min_u = rev4(sr[47:44]);
  assign min_d = rev3(sr[39:37]);
  assign hrs_u = rev4(sr[31:28]);
  assign hrs_d = rev2(sr[23:22]);
  assign ub = {rev4(sr[19:16]), rev4(sr[27:24]), rev4(sr[35:32]), rev4(sr[43:40]),
               rev4(sr[51:48]), rev4(sr[59:56]), rev4(sr[67:64]), rev4(sr[75:72])};
  assign unused_bits = ^{sr[52], sr[36], sr[21:20]};

  always_comb begin
    edge_det = s2 ^ s3;
    timed = cnt == SAT_C;
    classify = edge_det && !timed;
    glitch = classify && cnt < MIN_C;
    is_short = classify && cnt >= MIN_C && cnt < THR_C;
    is_long = classify && cnt >= THR_C;
    biphase = is_long && pending;
    emit = (is_short && pending) || (is_long && !pending);
    to_fault = timed && !timed_out && !edge_det;
    overrun = emit && locked && bit_cnt == 7'd80;
    fault = glitch || biphase || to_fault || overrun;
    sync_hit = emit_d && sr[15:0] == SYNC;
    full = bits_ok == 7'd80;
    bcd_ok = frm_u <= 4'd9 && sec_u <= 4'd9 && sec_d <= 3'd5 && min_u <= 4'd9 && min_d <= 3'd5 &&
             hrs_u <= 4'd9 && hrs_d <= 2'd2 && (hrs_d != 2'd2 || hrs_u <= 4'd3);
    good = sync_hit && full && bcd_ok && !fault;
    bad_bcd = sync_hit && full && !bcd_ok;
    lock_nxt = bit_cnt != 7'd80 ? LW'(1) : lock_cnt == LOCK_C ? lock_cnt : lock_cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
      cnt <= '0;
      timed_out <= 1'b0;
      pending <= 1'b0;
      emit_d <= 1'b0;
      sr <= '0;
      bits_ok <= '0;
      bit_cnt <= '0;
      lock_cnt <= '0;
      locked <= 1'b0;
      error <= 1'b0;
      frame_valid <= 1'b0;
      hrs <= '0;
      min <= '0;
      sec <= '0;
      frm <= '0;
      user_bits <= '0;
      drop_frame <= 1'b0;
      color_frame <= 1'b0;
    end else begin
      s1 <= ltc_in;
      s2 <= s1;
      s3 <= s2;
      cnt <= edge_det ? '0 : timed ? cnt : cnt + 1'b1;
      timed_out <= edge_det ? 1'b0 : timed_out || to_fault;
      pending <= fault ? 1'b0 : is_short ? !pending : pending;
      emit_d <= emit;
      if (emit) sr <= {sr[78:0], is_short};
      bits_ok <= fault ? '0 : (emit && !full) ? bits_ok + 1'b1 : bits_ok;
      bit_cnt <= sync_hit ? '0 : (emit && bit_cnt != 7'd127) ? bit_cnt + 1'b1 : bit_cnt;
      lock_cnt <= (fault || bad_bcd) ? '0 : good ? lock_nxt : lock_cnt;
      locked <= (fault || bad_bcd) ? 1'b0 : good ? lock_nxt >= LOCK_C : locked;
      error <= fault || bad_bcd;
      frame_valid <= good;
      if (good) begin
        hrs <= {hrs_d, hrs_u};
        min <= {min_d, min_u};
        sec <= {sec_d, sec_u};
        frm <= {frm_d, frm_u};
        user_bits <= ub;
        drop_frame <= sr[69];
        color_frame <= sr[68];
      end
    end
endmodule

// File: tb/tb_ltc_reader.sv
// tb_ltc_reader: random LTC frames encoded from timecode fields, decoded outputs checked against the source fields
module tb_ltc_reader;
  localparam int S25 = 15, L25 = 30, S24 = 16, L24 = 31, S30 = 12, L30 = 25;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic ltc_in = 1'b0;
  logic [5:0] hrs, frm;
  logic [6:0] min, sec;
  logic [31:0] user_bits;
  logic drop_frame, color_frame, frame_valid, locked, error;
  logic [59:0] obs_out, n_out, e_out;
  logic [79:0] fbits;
  int checks = 0, errors = 0, fv_n = 0, err_n = 0, lag = 0, streak = 0, f0 = 0, e0 = 0;

  ltc_reader #(.MIN_INTERVAL(8), .THRESHOLD(20), .MAX_INTERVAL(40), .CNT_W(6), .LOCK_FRAMES(2)) dut (
    .clk(clk), .reset_n(reset_n), .ltc_in(ltc_in), .hrs(hrs), .min(min), .sec(sec), .frm(frm),
    .user_bits(user_bits), .drop_frame(drop_frame), .color_frame(color_frame),
    .frame_valid(frame_valid), .locked(locked), .error(error)
  );

  assign obs_out = {hrs, min, sec, frm, user_bits, drop_frame, color_frame};

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_valid) fv_n <= fv_n + 1;
    if (error) err_n <= err_n + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b, input int s, input int l);
    if (b) begin
      cyc(s - lag);
      ltc_in = ~ltc_in;
      cyc(l - s);
    end else cyc(l - lag);
    lag = 0;
    ltc_in = ~ltc_in;
  endtask

  task automatic send_bits(input int lo, input int hi, input int s, input int l);
    for (int i = lo; i <= hi; i++) send_bit(fbits[i], s, l);
  endtask

  task automatic build(input int h, input int m, input int sc, input int f,
                       input logic [31:0] ub, input logic df, input logic cf);
    fbits = '0;
    fbits[3:0] = 4'(f % 10);
    fbits[7:4] = ub[3:0];
    fbits[9:8] = 2'(f / 10);
    fbits[10] = df;
    fbits[11] = cf;
    fbits[15:12] = ub[7:4];
    fbits[19:16] = 4'(sc % 10);
    fbits[23:20] = ub[11:8];
    fbits[26:24] = 3'(sc / 10);
    fbits[31:28] = ub[15:12];
    fbits[35:32] = 4'(m % 10);
    fbits[39:36] = ub[19:16];
    fbits[42:40] = 3'(m / 10);
    fbits[47:44] = ub[23:20];
    fbits[51:48] = 4'(h % 10);
    fbits[55:52] = ub[27:24];
    fbits[57:56] = 2'(h / 10);
    fbits[63:60] = ub[31:28];
    fbits[79:64] = 16'hBFFC;
    n_out = {2'(h / 10), 4'(h % 10), 3'(m / 10), 4'(m % 10), 3'(sc / 10), 4'(sc % 10),
             2'(f / 10), 4'(f % 10), ub, df, cf};
  endtask

  function automatic logic [31:0] rand_ub(input logic [3:0] ub1);
    logic [31:0] ub;
    ub[3:0] = ub1;
    for (int i = 1; i < 8; i++) ub[i*4 +: 4] = 4'($urandom_range(0, 9));
    return ub;
  endfunction

  task automatic build_rand(input int fps, input logic [3:0] ub1, input logic df);
    build(int'($urandom_range(0, 23)), int'($urandom_range(0, 59)), int'($urandom_range(0, 59)),
          int'($urandom_range(0, fps - 1)), rand_ub(ub1), df, 1'($urandom_range(0, 1)));
  endtask

  task automatic snap;
    f0 = fv_n;
    e0 = err_n;
  endtask

  task automatic settle;
    cyc(6);
    lag = 6;
  endtask

  task automatic good_frame(input string tag, input int s, input int l);
    snap();
    send_bits(0, 79, s, l);
    settle();
    streak++;
    e_out = n_out;
    chk({tag, "_fv"}, fv_n - f0, 1);
    chk({tag, "_err"}, err_n - e0, 0);
    chk({tag, "_out"}, obs_out, e_out);
    chk({tag, "_lock"}, locked, streak >= 2);
  endtask

  task automatic bad_checks(input string tag, input logic exact_one);
    streak = 0;
    chk({tag, "_fv"}, fv_n - f0, 0);
    if (exact_one) chk({tag, "_err"}, err_n - e0, 1);
    else chk({tag, "_err"}, err_n - e0 > 0, 1);
    chk({tag, "_lock"}, locked, 0);
    chk({tag, "_hold"}, obs_out, e_out);
  endtask

  initial begin
    e_out = '0;
    cyc(4);
    chk("reset_out", {obs_out, frame_valid, locked, error}, 0);
    reset_n = 1'b1;
    cyc(30);
    ltc_in = ~ltc_in;
    lag = 0;
    build(1, 23, 45, 12, rand_ub(4'($urandom_range(0, 9))), 1'b0, 1'b0);
    good_frame("fps25_a", S25, L25);
    chk("frm_a", frm, 6'h12);
    build(1, 23, 45, 13, rand_ub(4'($urandom_range(0, 9))), 1'b0, 1'b0);
    good_frame("fps25_b", S25, L25);
    chk("hrs_b", hrs, 6'h01);
    chk("min_b", min, 7'h23);
    chk("sec_b", sec, 7'h45);
    chk("frm_b", frm, 6'h13);
    for (int k = 0; k < 2; k++) begin
      build_rand(24, 4'hA, 1'b1);
      good_frame("fps24", S24, L24);
      chk("fps24_ub1", user_bits[3:0], 4'hA);
      chk("fps24_drop", drop_frame, 1);
    end
    for (int k = 0; k < 2; k++) begin
      build_rand(30, 4'hA, 1'b1);
      good_frame("fps30", S30, L30);
      chk("fps30_ub1", user_bits[3:0], 4'hA);
      chk("fps30_drop", drop_frame, 1);
    end
    snap();
    cyc(100);
    bad_checks("timeout", 1'b1);
    ltc_in = ~ltc_in;
    lag = 0;
    for (int k = 0; k < 2; k++) begin
      build_rand(25, 4'($urandom_range(0, 9)), 1'b0);
      good_frame("after_to", S25, L25);
    end
    build_rand(25, 4'($urandom_range(0, 9)), 1'b0);
    snap();
    send_bits(0, 9, S25, L25);
    cyc(3);
    ltc_in = ~ltc_in;
    lag = 3;
    send_bits(10, 79, S25, L25);
    settle();
    bad_checks("glitch", 1'b0);
    for (int k = 0; k < 2; k++) begin
      build_rand(25, 4'($urandom_range(0, 9)), 1'b0);
      good_frame("relock", S25, L25);
    end
    build_rand(25, 4'($urandom_range(0, 9)), 1'b0);
    fbits[3:0] = 4'hC;
    snap();
    send_bits(0, 79, S25, L25);
    settle();
    bad_checks("bcd", 1'b1);
    build_rand(25, 4'($urandom_range(0, 9)), 1'b0);
    snap();
    send_bits(0, 19, S25, L25);
    cyc(S25 - lag);
    lag = 0;
    ltc_in = ~ltc_in;
    cyc(L25);
    ltc_in = ~ltc_in;
    send_bits(21, 79, S25, L25);
    settle();
    bad_checks("biphase", 1'b0);
    build_rand(25, 4'($urandom_range(0, 9)), 1'b0);
    send_bits(0, 29, S25, L25);
    reset_n = 1'b0;
    ltc_in = 1'b0;
    #1;
    chk("mid_reset", {obs_out, frame_valid, locked, error}, 0);
    cyc(3);
    reset_n = 1'b1;
    e_out = '0;
    streak = 0;
    cyc(30);
    ltc_in = ~ltc_in;
    lag = 0;
    for (int k = 0; k < 2; k++) begin
      build_rand(25, 4'($urandom_range(0, 9)), 1'b0);
      good_frame("post_reset", S25, L25);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
